// File: rtl/commit_scheduler.sv
// Commit scheduler: buffers up to two ROB commits per cycle in a circular FIFO and
// retires one per cycle to the register file, sequencing ROB rollbacks after a full drain.
module commit_scheduler #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             rob_c0_valid_in,
  input  logic             rob_c0_rf_in,
  input  logic [TAG_W-1:0] rob_c0_tag_in,
  input  logic [31:0]      rob_c0_data_in,
  input  logic [4:0]       rob_c0_target_in,
  input  logic [31:0]      rob_c0_pc_in,

  input  logic             rob_c1_valid_in,
  input  logic             rob_c1_rf_in,
  input  logic [TAG_W-1:0] rob_c1_tag_in,
  input  logic [31:0]      rob_c1_data_in,
  input  logic [4:0]       rob_c1_target_in,
  input  logic [31:0]      rob_c1_pc_in,

  input  logic             rob_rollback_req_in,
  output logic             rob_ready_out,
  output logic             rob_rollback_done_out,

  output logic             rf_commit_signal_out,
  output logic             rf_commit_rf_signal_out,
  output logic [TAG_W-1:0] rf_commit_tag_out,
  output logic [31:0]      rf_commit_data_out,
  output logic [4:0]       rf_commit_target_out,
  output logic [31:0]      rf_commit_pc_out,
  output logic             rf_rollback_out,
  output logic             idle_out
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_ROLLBACK
  } state_e;

  typedef struct packed {
    logic             rf;
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
    logic [4:0]       target;
    logic [31:0]      pc;
  } entry_t;

  // Explicit wrap so non-power-of-two depths stay correct.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  entry_t mem_q [DEPTH];

  state_e state_q, state_d;
  ptr_t   head_q, head_d;
  ptr_t   tail_q, tail_d;
  cnt_t   count_q, count_d;
  logic   commit_sig_q, commit_sig_d;
  entry_t commit_ent_q, commit_ent_d;

  logic   push0, push1, pop;
  ptr_t   tail_p1;
  entry_t slot0, slot1;

  assign slot0 = '{rf: rob_c0_rf_in, tag: rob_c0_tag_in, data: rob_c0_data_in,
                   target: rob_c0_target_in, pc: rob_c0_pc_in};
  assign slot1 = '{rf: rob_c1_rf_in, tag: rob_c1_tag_in, data: rob_c1_data_in,
                   target: rob_c1_target_in, pc: rob_c1_pc_in};

  // Status is decoded from registers only, so the ROB sees no combinational path from its own inputs.
  assign rob_ready_out         = (state_q == S_RUN) && (count_q <= cnt_t'(DEPTH - 2));
  assign idle_out              = (state_q == S_RUN) && (count_q == '0);
  assign rf_rollback_out       = (state_q == S_ROLLBACK);
  assign rob_rollback_done_out = (state_q == S_ROLLBACK);

  assign rf_commit_signal_out    = commit_sig_q;
  assign rf_commit_rf_signal_out = commit_ent_q.rf;
  assign rf_commit_tag_out       = commit_ent_q.tag;
  assign rf_commit_data_out      = commit_ent_q.data;
  assign rf_commit_target_out    = commit_ent_q.target;
  assign rf_commit_pc_out        = commit_ent_q.pc;

  // A lone slot-1 valid is illegal and dropped; slot 1 only follows an accepted slot 0.
  assign push0   = rob_ready_out && rob_c0_valid_in;
  assign push1   = push0 && rob_c1_valid_in;
  assign pop     = (count_q != '0) && ((state_q == S_RUN) || (state_q == S_DRAIN));
  assign tail_p1 = ptr_inc(tail_q);

  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    head_d       = head_q;
    tail_d       = tail_q;
    commit_sig_d = pop;
    commit_ent_d = '0;

    if (pop) begin
      commit_ent_d = mem_q[head_q];
      head_d       = ptr_inc(head_q);
    end

    if (push1)      tail_d = ptr_inc(tail_p1);
    else if (push0) tail_d = tail_p1;

    count_d = count_q + cnt_t'(push0) + cnt_t'(push1) - cnt_t'(pop);

    case (state_q)
      S_RUN:      if (rob_rollback_req_in) state_d = S_DRAIN;
      S_DRAIN:    if (count_q == '0)       state_d = S_ROLLBACK;
      S_ROLLBACK: state_d = S_RUN;
      default:    state_d = S_RUN;
    endcase
  end

  // NOTE: storage is not reset; head/tail/count reset makes stale contents unreachable.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (push0) mem_q[tail_q]  <= slot0;
      if (push1) mem_q[tail_p1] <= slot1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_RUN;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      commit_sig_q <= 1'b0;
      commit_ent_q <= '0;
    end else begin
      state_q      <= state_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      commit_sig_q <= commit_sig_d;
      commit_ent_q <= commit_ent_d;
    end
  end

endmodule

// File: tb/tb_commit_scheduler.sv
// Self-checking bench for commit_scheduler: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_commit_scheduler;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;
  localparam int P_RUN = 0, P_DRAIN = 1, P_RB = 2;

  typedef struct packed {
    logic             rf;
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
    logic [4:0]       target;
    logic [31:0]      pc;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic c0v = 1'b0, c1v = 1'b0, req = 1'b0;
  ent_t s0 = '0, s1 = '0;

  logic             rob_ready_out, rob_rollback_done_out;
  logic             rf_commit_signal_out, rf_commit_rf_signal_out;
  logic [TAG_W-1:0] rf_commit_tag_out;
  logic [31:0]      rf_commit_data_out, rf_commit_pc_out;
  logic [4:0]       rf_commit_target_out;
  logic             rf_rollback_out, idle_out;

  always #5 clk = ~clk;

  commit_scheduler #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .rob_c0_valid_in(c0v), .rob_c0_rf_in(s0.rf), .rob_c0_tag_in(s0.tag),
    .rob_c0_data_in(s0.data), .rob_c0_target_in(s0.target), .rob_c0_pc_in(s0.pc),
    .rob_c1_valid_in(c1v), .rob_c1_rf_in(s1.rf), .rob_c1_tag_in(s1.tag),
    .rob_c1_data_in(s1.data), .rob_c1_target_in(s1.target), .rob_c1_pc_in(s1.pc),
    .rob_rollback_req_in(req), .rob_ready_out(rob_ready_out),
    .rob_rollback_done_out(rob_rollback_done_out),
    .rf_commit_signal_out(rf_commit_signal_out), .rf_commit_rf_signal_out(rf_commit_rf_signal_out),
    .rf_commit_tag_out(rf_commit_tag_out), .rf_commit_data_out(rf_commit_data_out),
    .rf_commit_target_out(rf_commit_target_out), .rf_commit_pc_out(rf_commit_pc_out),
    .rf_rollback_out(rf_rollback_out), .idle_out(idle_out)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: pending commits in ROB order, the phase, and the expected RF output.
  ent_t             q[$];
  int               phase = P_RUN;
  bit               started = 1'b0;
  logic             e_sig = 1'b0;
  ent_t             e_ent = '0;
  logic [TAG_W-1:0] log_tags[$];

  function automatic bit m_ready();
    return (phase == P_RUN) && (q.size() <= DEPTH - 2);
  endfunction

  function automatic bit m_idle();
    return (phase == P_RUN) && (q.size() == 0);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_outputs();
    if (!started) return;
    check("commit_signal", 64'(rf_commit_signal_out), 64'(e_sig));
    check("commit_rf",     64'(rf_commit_rf_signal_out), 64'(e_ent.rf));
    check("commit_tag",    64'(rf_commit_tag_out), 64'(e_ent.tag));
    check("commit_data",   64'(rf_commit_data_out), 64'(e_ent.data));
    check("commit_target", 64'(rf_commit_target_out), 64'(e_ent.target));
    check("commit_pc",     64'(rf_commit_pc_out), 64'(e_ent.pc));
    check("rf_rollback",   64'(rf_rollback_out), 64'(phase == P_RB));
    check("rollback_done", 64'(rob_rollback_done_out), 64'(phase == P_RB));
    check("rob_ready",     64'(rob_ready_out), 64'(m_ready()));
    check("idle",          64'(idle_out), 64'(m_idle()));
  endtask

  task automatic model_edge();
    int  pre;
    bit  rdy;
    if (rst) begin
      q.delete();
      phase   = P_RUN;
      e_sig   = 1'b0;
      e_ent   = '0;
      started = 1'b1;
      return;
    end
    rdy = m_ready();
    pre = q.size();
    if (pre > 0 && phase != P_RB) begin
      e_sig = 1'b1;
      e_ent = q.pop_front();
    end else begin
      e_sig = 1'b0;
      e_ent = '0;
    end
    if (rdy && c0v) begin
      q.push_back(s0);
      if (c1v) q.push_back(s1);
    end
    if (phase == P_RUN) begin
      if (req) phase = P_DRAIN;
    end else if (phase == P_DRAIN) begin
      if (pre == 0) phase = P_RB;
    end else begin
      phase = P_RUN;
    end
  endtask

  task automatic tick();
    compare_outputs();
    if (started && rf_commit_signal_out === 1'b1) log_tags.push_back(rf_commit_tag_out);
    model_edge();
    @(posedge clk);
    #1;
  endtask

  function automatic ent_t mk(input int t);
    ent_t e;
    e.rf     = 1'b1;
    e.tag    = TAG_W'(t);
    e.data   = 32'h1000 + 32'(t);
    e.target = 5'(t);
    e.pc     = 32'(t) * 4;
    return e;
  endfunction

  function automatic ent_t rand_ent();
    ent_t e;
    e.rf     = 1'($urandom_range(0, 1));
    e.tag    = TAG_W'($urandom_range(1, 15));
    e.data   = $urandom;
    e.target = 5'($urandom_range(0, 31));
    e.pc     = $urandom & 32'hFFFF_FFFC;
    return e;
  endfunction

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!m_idle() && n < 50) begin
      tick();
      n++;
    end
    check(tag, 64'(n < 50), 64'(1));
  endtask

  // Holds the offer until the model says the scheduler is ready, then presents it for one edge.
  task automatic offer(input ent_t a, input ent_t b, input bit two);
    int n = 0;
    s0 = a; s1 = b; c0v = 1'b1; c1v = two;
    while (!m_ready() && n < 20) begin
      tick();
      n++;
    end
    check("offer_ready_bound", 64'(n < 20), 64'(1));
    tick();
    c0v = 1'b0; c1v = 1'b0;
  endtask

  // Counts deliveries until the rollback pulse appears; returns the count.
  task automatic run_to_rollback(input string tag, output int dels);
    int n = 0;
    dels = 0;
    while (rf_rollback_out !== 1'b1 && n < 20) begin
      if (rf_commit_signal_out === 1'b1) dels++;
      tick();
      n++;
    end
    check(tag, 64'(n < 20), 64'(1));
  endtask

  initial begin
    int base;
    int dels;

    // Reset
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("reset_ready", 64'(rob_ready_out), 64'(1));
    check("reset_idle",  64'(idle_out), 64'(1));
    check("reset_sig",   64'(rf_commit_signal_out), 64'(0));
    check("reset_rb",    64'(rf_rollback_out), 64'(0));

    // Single commit: visible only after the second edge
    s0 = '{rf: 1'b1, tag: 4'd3, data: 32'hDEADBEEF, target: 5'd5, pc: 32'h0000_0100};
    c0v = 1'b1;
    tick();
    c0v = 1'b0;
    check("single_not_yet", 64'(rf_commit_signal_out), 64'(0));
    tick();
    check("single_sig",    64'(rf_commit_signal_out), 64'(1));
    check("single_tag",    64'(rf_commit_tag_out), 64'(3));
    check("single_data",   64'(rf_commit_data_out), 64'(32'hDEADBEEF));
    check("single_target", 64'(rf_commit_target_out), 64'(5));
    tick();
    check("single_one_cycle", 64'(rf_commit_signal_out), 64'(0));

    // Dual commits, tags 1..6, across pointer wrap
    wait_idle("idle_before_dual");
    base = log_tags.size();
    offer(mk(1), mk(2), 1'b1);
    offer(mk(3), mk(4), 1'b1);
    check("dual_ready_falls", 64'(rob_ready_out), 64'(0));
    offer(mk(5), mk(6), 1'b1);
    wait_idle("idle_after_dual");
    tick();
    check("dual_count", 64'(log_tags.size() - base), 64'(6));
    for (int i = 0; i < 6; i++)
      if (base + i < log_tags.size())
        check("dual_order", 64'(log_tags[base + i]), 64'(i + 1));

    // Rollback with 3 buffered
    wait_idle("idle_before_rb3");
    offer(mk(7), mk(8), 1'b1);
    offer(mk(9), mk(10), 1'b1);
    req = 1'b1;
    tick();
    req = 1'b0;
    run_to_rollback("rb3_reached", dels);
    check("rb3_deliveries", 64'(dels), 64'(3));
    check("rb3_done",       64'(rob_rollback_done_out), 64'(1));
    check("rb3_no_commit",  64'(rf_commit_signal_out), 64'(0));
    tick();
    check("rb3_pulse_once", 64'(rf_rollback_out), 64'(0));
    check("rb3_ready_back", 64'(rob_ready_out), 64'(1));

    // Rollback together with two commits into an empty FIFO
    wait_idle("idle_before_rb2");
    s0 = mk(11); s1 = mk(12); c0v = 1'b1; c1v = 1'b1; req = 1'b1;
    tick();
    c0v = 1'b0; c1v = 1'b0; req = 1'b0;
    run_to_rollback("rb2_reached", dels);
    check("rb2_deliveries", 64'(dels), 64'(2));

    // Rollback while idle
    wait_idle("idle_before_rb0");
    req = 1'b1;
    tick();
    req = 1'b0;
    check("rb0_drain_sig",   64'(rf_commit_signal_out), 64'(0));
    check("rb0_drain_rb",    64'(rf_rollback_out), 64'(0));
    check("rb0_drain_ready", 64'(rob_ready_out), 64'(0));
    tick();
    check("rb0_pulse", 64'(rf_rollback_out), 64'(1));
    check("rb0_sig",   64'(rf_commit_signal_out), 64'(0));
    tick();
    check("rb0_ready_back", 64'(rob_ready_out), 64'(1));

    // Reset in the middle of a drain
    wait_idle("idle_before_rstdrain");
    offer(mk(13), mk(14), 1'b1);
    offer(mk(15), mk(1), 1'b1);
    req = 1'b1;
    tick();
    req = 1'b0;
    check("rstdrain_in_drain", 64'(rob_ready_out), 64'(0));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstdrain_ready", 64'(rob_ready_out), 64'(1));
    check("rstdrain_idle",  64'(idle_out), 64'(1));
    check("rstdrain_sig",   64'(rf_commit_signal_out), 64'(0));
    base = log_tags.size();
    dels = 0;
    repeat (6) begin
      if (rf_rollback_out === 1'b1) dels++;
      tick();
    end
    check("rstdrain_no_commits", 64'(log_tags.size() - base), 64'(0));
    check("rstdrain_no_rb",      64'(dels), 64'(0));

    // Random traffic, including illegal lone slot-1 valids, rollbacks and resets
    repeat (3000) begin
      s0  = rand_ent();
      s1  = rand_ent();
      c0v = 1'($urandom_range(0, 1));
      c1v = 1'($urandom_range(0, 1));
      req = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    c0v = 1'b0; c1v = 1'b0; req = 1'b0; rst = 1'b0;
    wait_idle("idle_after_random");
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
